// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port, one read port with a
// registered output that only changes when a read is requested.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array has no reset so it can map onto block RAM; the caller gates we_i.
    always_ff @(posedge ACLK) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO used to queue AXI burst lengths (AR->R, AW->W).
// Pointers, occupancy and flags live here; storage is in sync_fifo_ram.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   fifo_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    // Flags decode the registered count, so they move on the same edge as it.
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + ONE_C;
        else if (pop_ok && !push_ok) count_d = count_q - ONE_C;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Read and write never hit the same slot in one cycle: equal pointers
    // mean empty (no read) or full (no write).
    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .we_i    (push_ok & ARESETN),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (pop_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign fifo_count = count_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model tracks expected contents,
// count, flags and data_out, checked one step after every rising edge.
module tb_sync_fifo;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          push, pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty, full;
    logic [AW:0]   fifo_count;

    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_dout;
    int            pushed;

    always #5 ACLK = ~ACLK;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(sb_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(sb_q.size() == DEPTH));
        chk({tag, ".dout"},  32'(data_out), 32'(exp_dout));
    endtask

    // Drive one cycle, advance the model, then check after the edge.
    task automatic step(input logic p, input logic r, input logic [DW-1:0] d, input string tag);
        bit pok, rok;
        push = p; pop = r; data_in = d;
        pok = p && (sb_q.size() < DEPTH);
        rok = r && (sb_q.size() > 0);
        @(posedge ACLK); #1;
        if (rok) exp_dout = sb_q.pop_front();
        if (pok) sb_q.push_back(d);
        check_state(tag);
    endtask

    task automatic do_reset(input int cycles);
        ARESETN = 1'b0; push = 1'b1; pop = 1'b0; data_in = 16'hAAAA;
        repeat (cycles) @(posedge ACLK);
        #1;
        sb_q.delete();
        exp_dout = '0;
        ARESETN = 1'b1; push = 1'b0;
        check_state("reset");
    endtask

    task automatic drain(input string tag);
        while (sb_q.size() > 0) step(1'b0, 1'b1, '0, tag);
    endtask

    initial begin
        ARESETN = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; exp_dout = '0;
        #1;
        do_reset(2);

        // Ordered transfer
        step(1, 0, 16'd3,  "ord.push");
        step(1, 0, 16'd7,  "ord.push");
        step(1, 0, 16'd15, "ord.push");
        repeat (3) step(0, 1, '0, "ord.pop");

        // Fill, overflow attempt, full drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), "fill.push");
        step(1, 0, 16'hFFFF, "fill.ovf");
        drain("fill.pop");

        // Underflow holds data_out
        step(1, 0, 16'd5, "uf.push5");
        step(0, 1, '0,    "uf.pop5");
        step(0, 1, '0,    "uf.pop_empty");
        step(0, 1, '0,    "uf.pop_empty2");
        step(1, 0, 16'd9, "uf.push9");
        step(0, 1, '0,    "uf.pop9");

        // Simultaneous push/pop: mid, empty, full
        step(1, 0, 16'd4, "sim.push4");
        step(1, 0, 16'd6, "sim.push6");
        step(1, 1, 16'd8, "sim.mid");
        drain("sim.drain1");
        step(1, 1, 16'h1234, "sim.empty");
        drain("sim.drain2");
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i + 100), "sim.fill");
        step(1, 1, 16'hBEEF, "sim.full");
        drain("sim.drain3");

        // Streaming wrap-around with occupancy held in 1..4
        pushed = 0;
        step(1, 0, 16'h0, "wrap.prime");
        pushed++;
        while (pushed < 3000) begin
            bit p, r;
            p = (sb_q.size() < 4) && ($urandom_range(3) != 0);
            r = (sb_q.size() > 1) && ($urandom_range(3) != 0);
            if (!p && !r) begin
                if (sb_q.size() < 4) p = 1'b1; else r = 1'b1;
            end
            step(p, r, DW'(pushed * 7 + 1), "wrap");
            if (p) pushed++;
        end
        drain("wrap.drain");

        // Reset mid-operation discards contents
        step(1, 0, 16'h55, "rst2.push");
        step(1, 0, 16'h66, "rst2.push");
        step(0, 1, '0,     "rst2.pop");
        do_reset(1);
        step(0, 1, '0, "rst2.pop_after");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in/first-out queue with a parameterised data width and a power-of-two depth.
- Used by the AXI slave bus-functional driver to queue burst lengths between the address channels and the data channels: AR feeds R, AW feeds W.
- Provides registered read data, full/empty flags and an occupancy count.

Parameters:
- DATA_WIDTH, default 16: width of each stored word in bits.
- ADDR_WIDTH, default 10: pointer width; depth DEPTH = 2**ADDR_WIDTH entries (1024 at default).

Ports:
- ACLK  input  1  clock; all state changes on the rising edge.
- ARESETN  input  1  synchronous active-low reset.
- push  input  1  write request; data_in is stored when accepted.
- pop  input  1  read request; head entry moves to data_out when accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when the count is 0.
- full  output  1  high when the count equals DEPTH.
- fifo_count  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.

Behaviour:
- Reset: on a rising ACLK edge with ARESETN=0:
  - write pointer, read pointer and count go to 0;
  - data_out goes to 0; empty=1; full=0.
  - Memory contents are not cleared.
  - Reset overrides push and pop in the same cycle. A reset mid-operation discards all queued data.
- Storage: DEPTH x DATA_WIDTH array. Read and write pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Acceptance rules, evaluated at the rising edge:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - A push while full is ignored: no write, no pointer or count change.
  - A pop while empty is ignored: data_out holds its value.
- Write: when push_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read:
  - When pop_ok, data_out <= mem[rd_ptr] and rd_ptr increments.
  - Read latency is one cycle: data is valid on data_out immediately after the edge that accepted the pop, and holds until the next accepted pop.
  - data_out is never updated without an accepted pop.
- Simultaneous push and pop:
  - Not empty and not full: both are accepted; count is unchanged; data_out receives the old head, never the incoming word.
  - Empty: only the push is accepted; count becomes 1; data_out is unchanged.
  - Full: only the pop is accepted; count becomes DEPTH-1.
- Count:
  - Increments on push_ok only.
  - Decrements on pop_ok only.
  - Unchanged on both or neither.
- Flags:
  - empty and full are driven from registered state, i.e. the count register or equivalent registered flags.
  - Both update in the same edge as the count.
  - empty and full are never asserted together.
- No bypass path: a word pushed into an empty FIFO can be popped no earlier than the following cycle.

Decomposition:
- No shared package is required. DEPTH is a localparam derived from ADDR_WIDTH.
- One natural sub-module: sync_fifo_ram.
  - Simple dual-port memory: one write port, one read port with a registered output.
  - Clocked by ACLK; holds the mem array and drives data_out.
  - The top level keeps pointers, count and flags.

Test Plan:
- Reset: hold ARESETN=0 for 2 cycles with push=1 and data_in=16'hAAAA -> empty=1, full=0, fifo_count=0, data_out=0 after release.
- Ordered transfer: push 3, 7, 15 on consecutive cycles, then pop 3 times -> data_out = 3, 7, 15, each valid the cycle after its pop edge; fifo_count goes 1, 2, 3, 2, 1, 0; empty returns to 1.
- Fill and overflow: push 1024 words with values 0..1023 -> full=1, fifo_count=1024; a 1025th push of 16'hFFFF is ignored; popping all 1024 returns 0..1023 in order and never returns FFFF.
- Underflow: with the FIFO empty and data_out=5, assert pop -> data_out stays 5, fifo_count stays 0, no pointer movement; a subsequent push of 9 then pop yields 9.
- Simultaneous push/pop:
  - Count 2 (head 4): push 8 with pop -> data_out=4, count stays 2.
  - Empty: push with pop -> count=1, data_out unchanged.
  - Full: push with pop -> count=1023, pushed word dropped.
- Wrap-around: push/pop 3000 words streaming with count kept between 1 and 4 -> every word emerges in order across multiple pointer wraps; full is never asserted.
